dffram_nibble_sequencer: RTL and testbench

- Command front-end that sits directly upstream of the 32x8 2R1W nibble-wide DFF RAM and drives its external nibble interface.
- Converts whole-byte write/read commands, carried on a valid/ready handshake, into the two-cycle lo/hi nibble sequences the RAM needs.
- Reassembles read nibbles from RAM ports A and B into bytes and returns them on a valid/ready response channel.
- One command is outstanding at a time.

---
 rtl/dffram_nibble_sequencer.sv | 173 +++++++++++++++++
 tb/tb_dffram_nibble_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dffram_nibble_sequencer.sv
// Byte-command front-end for the nibble-wide 2R1W DFF RAM.
// Handshake semantics (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high; the producer holds valid and payload
// stable until that edge, and ready never depends on valid.
// A write byte is split into a lo-nibble then hi-nibble write on port A; a read
// fetches lo then hi nibbles from ports A and B and returns two bytes.
// All ram_* outputs are registers, so cmd_* inputs never reach the RAM
// combinationally.
module dffram_nibble_sequencer #(
    parameter int RD_LAT = 0,
    parameter int AW     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr_a,
    input  logic [AW-1:0] cmd_addr_b,
    input  logic [7:0]    cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [7:0]    rsp_data_a,
    output logic [7:0]    rsp_data_b,
    output logic [AW-1:0] ram_addr_a,
    output logic [AW-1:0] ram_addr_b,
    output logic [3:0]    ram_wdata,
    output logic          ram_lohi_a,
    output logic          ram_lohi_b,
    output logic          ram_w_en,
    input  logic [3:0]    ram_rdata_a,
    input  logic [3:0]    ram_rdata_b,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_LO    = 3'd1,
        WR_HI    = 3'd2,
        RD_LO    = 3'd3,
        RD_HI    = 3'd4,
        RD_DRAIN = 3'd5,
        RSP      = 3'd6
    } state_t;

    state_t        state_q;

    // Latched command; the lo write nibble goes straight into ram_wdata_q at accept.
    logic [AW-1:0] addr_a_q;
    logic [AW-1:0] addr_b_q;
    logic [3:0]    wdata_hi_q;

    // Registered RAM-side outputs.
    logic [AW-1:0] ram_addr_a_q;
    logic [AW-1:0] ram_addr_b_q;
    logic [3:0]    ram_wdata_q;
    logic          ram_lohi_a_q;
    logic          ram_lohi_b_q;
    logic          ram_w_en_q;

    // Response bytes, assembled nibble by nibble and held until the next read.
    logic [7:0]    rsp_a_q;
    logic [7:0]    rsp_b_q;

    // Sequencer FSM: state, command latch, RAM output registers and read capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            wdata_hi_q   <= '0;
            ram_addr_a_q <= '0;
            ram_addr_b_q <= '0;
            ram_wdata_q  <= '0;
            ram_lohi_a_q <= 1'b0;
            ram_lohi_b_q <= 1'b0;
            ram_w_en_q   <= 1'b0;
            rsp_a_q      <= 8'h00;
            rsp_b_q      <= 8'h00;
        end else begin
            // RAM outputs idle at zero unless the next state drives them.
            ram_addr_a_q <= '0;
            ram_addr_b_q <= '0;
            ram_wdata_q  <= '0;
            ram_lohi_a_q <= 1'b0;
            ram_lohi_b_q <= 1'b0;
            ram_w_en_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_a_q   <= cmd_addr_a;
                        addr_b_q   <= cmd_addr_b;
                        wdata_hi_q <= cmd_wdata[7:4];
                        ram_addr_a_q <= cmd_addr_a;
                        if (cmd_write) begin
                            // RAM writes bits[3:0] when lohi_a=1.
                            state_q      <= WR_LO;
                            ram_w_en_q   <= 1'b1;
                            ram_lohi_a_q <= 1'b1;
                            ram_wdata_q  <= cmd_wdata[3:0];
                        end else begin
                            state_q      <= RD_LO;
                            ram_addr_b_q <= cmd_addr_b;
                        end
                    end
                end
                WR_LO: begin
                    state_q      <= WR_HI;
                    ram_w_en_q   <= 1'b1;
                    ram_addr_a_q <= addr_a_q;
                    ram_wdata_q  <= wdata_hi_q;
                end
                WR_HI: begin
                    state_q <= IDLE;
                end
                RD_LO: begin
                    if (RD_LAT == 0) begin
                        rsp_a_q[3:0] <= ram_rdata_a;
                        rsp_b_q[3:0] <= ram_rdata_b;
                    end
                    state_q      <= RD_HI;
                    ram_addr_a_q <= addr_a_q;
                    ram_addr_b_q <= addr_b_q;
                    ram_lohi_a_q <= 1'b1;
                    ram_lohi_b_q <= 1'b1;
                end
                RD_HI: begin
                    if (RD_LAT == 0) begin
                        rsp_a_q[7:4] <= ram_rdata_a;
                        rsp_b_q[7:4] <= ram_rdata_b;
                        state_q      <= RSP;
                    end else begin
                        // Buffered RAM: the lo nibble arrives one cycle late.
                        rsp_a_q[3:0] <= ram_rdata_a;
                        rsp_b_q[3:0] <= ram_rdata_b;
                        state_q      <= RD_DRAIN;
                        ram_addr_a_q <= addr_a_q;
                        ram_addr_b_q <= addr_b_q;
                        ram_lohi_a_q <= 1'b1;
                        ram_lohi_b_q <= 1'b1;
                    end
                end
                RD_DRAIN: begin
                    rsp_a_q[7:4] <= ram_rdata_a;
                    rsp_b_q[7:4] <= ram_rdata_b;
                    state_q      <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Status and channel outputs decoded from the registered state.
    assign cmd_ready  = rst_n && (state_q == IDLE);
    assign rsp_valid  = (state_q == RSP);
    assign busy       = (state_q != IDLE);
    assign rsp_data_a = rsp_a_q;
    assign rsp_data_b = rsp_b_q;
    assign ram_addr_a = ram_addr_a_q;
    assign ram_addr_b = ram_addr_b_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_lohi_a = ram_lohi_a_q;
    assign ram_lohi_b = ram_lohi_b_q;
    assign ram_w_en   = ram_w_en_q;

endmodule

// File: tb/tb_dffram_nibble_sequencer.sv
// Bench for dffram_nibble_sequencer: one instance against an unbuffered RAM
// model (RD_LAT=0) and one against a buffered RAM model (RD_LAT=1).
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_dffram_nibble_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance 0 signals (RD_LAT=0)
    logic       c0_valid = 0, c0_write = 0, c0_ready, r0_valid, r0_ready = 0;
    logic [3:0] c0_addr_a = 0, c0_addr_b = 0;
    logic [7:0] c0_wdata = 0, r0_da, r0_db;
    logic [3:0] m0_addr_a, m0_addr_b, m0_wdata, m0_rd_a, m0_rd_b;
    logic       m0_lohi_a, m0_lohi_b, m0_w_en, busy0;

    // Instance 1 signals (RD_LAT=1)
    logic       c1_valid = 0, c1_write = 0, c1_ready, r1_valid, r1_ready = 0;
    logic [3:0] c1_addr_a = 0, c1_addr_b = 0;
    logic [7:0] c1_wdata = 0, r1_da, r1_db;
    logic [3:0] m1_addr_a, m1_addr_b, m1_wdata, m1_rd_a, m1_rd_b;
    logic       m1_lohi_a, m1_lohi_b, m1_w_en, busy1;

    dffram_nibble_sequencer #(.RD_LAT(0), .AW(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_write(c0_write),
        .cmd_addr_a(c0_addr_a), .cmd_addr_b(c0_addr_b), .cmd_wdata(c0_wdata),
        .rsp_valid(r0_valid), .rsp_ready(r0_ready), .rsp_data_a(r0_da), .rsp_data_b(r0_db),
        .ram_addr_a(m0_addr_a), .ram_addr_b(m0_addr_b), .ram_wdata(m0_wdata),
        .ram_lohi_a(m0_lohi_a), .ram_lohi_b(m0_lohi_b), .ram_w_en(m0_w_en),
        .ram_rdata_a(m0_rd_a), .ram_rdata_b(m0_rd_b), .busy(busy0)
    );

    dffram_nibble_sequencer #(.RD_LAT(1), .AW(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_write(c1_write),
        .cmd_addr_a(c1_addr_a), .cmd_addr_b(c1_addr_b), .cmd_wdata(c1_wdata),
        .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_data_a(r1_da), .rsp_data_b(r1_db),
        .ram_addr_a(m1_addr_a), .ram_addr_b(m1_addr_b), .ram_wdata(m1_wdata),
        .ram_lohi_a(m1_lohi_a), .ram_lohi_b(m1_lohi_b), .ram_w_en(m1_w_en),
        .ram_rdata_a(m1_rd_a), .ram_rdata_b(m1_rd_b), .busy(busy1)
    );

    // Unbuffered RAM model: write lohi_a=1 -> bits[3:0]; read lohi=1 -> bits[7:4].
    logic [7:0] mem0 [16];
    always @(posedge clk) begin
        if (m0_w_en) begin
            if (m0_lohi_a) mem0[m0_addr_a][3:0] <= m0_wdata;
            else           mem0[m0_addr_a][7:4] <= m0_wdata;
        end
    end
    assign m0_rd_a = m0_lohi_a ? mem0[m0_addr_a][7:4] : mem0[m0_addr_a][3:0];
    assign m0_rd_b = m0_lohi_b ? mem0[m0_addr_b][7:4] : mem0[m0_addr_b][3:0];

    // Buffered RAM model: read data lags the address by one clock.
    logic [7:0] mem1 [16];
    always @(posedge clk) begin
        if (m1_w_en) begin
            if (m1_lohi_a) mem1[m1_addr_a][3:0] <= m1_wdata;
            else           mem1[m1_addr_a][7:4] <= m1_wdata;
        end
        m1_rd_a <= m1_lohi_a ? mem1[m1_addr_a][7:4] : mem1[m1_addr_a][3:0];
        m1_rd_b <= m1_lohi_b ? mem1[m1_addr_b][7:4] : mem1[m1_addr_b][3:0];
    end

    // Running count of cycles with ram_w_en high on instance 0.
    int wen0_cnt = 0;
    always @(posedge clk) if (m0_w_en) wen0_cnt <= wen0_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick();
        tick();
        checks++; if (c0_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %0b exp 0", c0_ready); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b exp 0", busy0); end
        checks++; if (r0_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0b exp 0", r0_valid); end
        checks++; if ({r0_da, r0_db} !== 16'h0000) begin errors++; $display("FAIL rst_rsp_data: got %h exp 0000", {r0_da, r0_db}); end
        checks++; if ({m0_w_en, m0_lohi_a, m0_lohi_b, m0_addr_a, m0_addr_b, m0_wdata} !== 15'h0) begin
            errors++; $display("FAIL rst_ram_outputs: got %h exp 0", {m0_w_en, m0_lohi_a, m0_lohi_b, m0_addr_a, m0_addr_b, m0_wdata}); end
        checks++; if (c1_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready1: got %0b exp 0", c1_ready); end
        rst_n = 1;
        tick();
        checks++; if (c0_ready !== 1'b1) begin errors++; $display("FAIL post_rst_cmd_ready: got %0b exp 1", c0_ready); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %0b exp 0", busy0); end
    endtask

    task automatic test_write_read();
        int base;
        base = wen0_cnt;
        c0_valid = 1; c0_write = 1; c0_addr_a = 3; c0_addr_b = 4'hF; c0_wdata = 8'hA5;
        tick(); // WR_LO
        c0_valid = 0;
        checks++; if ({m0_w_en, m0_lohi_a, m0_wdata, m0_addr_a} !== {1'b1, 1'b1, 4'h5, 4'h3}) begin
            errors++; $display("FAIL wr_lo_ram: got w_en=%0b lohi=%0b wdata=%h addr=%h exp 1 1 5 3", m0_w_en, m0_lohi_a, m0_wdata, m0_addr_a); end
        checks++; if ({busy0, c0_ready} !== 2'b10) begin errors++; $display("FAIL wr_lo_status: got busy=%0b ready=%0b exp 1 0", busy0, c0_ready); end
        tick(); // WR_HI
        checks++; if ({m0_w_en, m0_lohi_a, m0_wdata, m0_addr_a} !== {1'b1, 1'b0, 4'hA, 4'h3}) begin
            errors++; $display("FAIL wr_hi_ram: got w_en=%0b lohi=%0b wdata=%h addr=%h exp 1 0 a 3", m0_w_en, m0_lohi_a, m0_wdata, m0_addr_a); end
        tick(); // IDLE, T+3
        checks++; if ({m0_w_en, c0_ready, r0_valid} !== 3'b010) begin
            errors++; $display("FAIL wr_done: got w_en=%0b ready=%0b rsp_valid=%0b exp 0 1 0", m0_w_en, c0_ready, r0_valid); end
        checks++; if (wen0_cnt - base !== 2) begin errors++; $display("FAIL wr_wen_pulses: got %0d exp 2", wen0_cnt - base); end
        checks++; if (mem0[3] !== 8'hA5) begin errors++; $display("FAIL wr_mem: got %h exp a5", mem0[3]); end

        c0_valid = 1; c0_write = 0; c0_addr_a = 3; c0_addr_b = 3;
        tick(); // RD_LO
        c0_valid = 0;
        checks++; if ({m0_addr_a, m0_addr_b, m0_lohi_a, m0_lohi_b, m0_w_en, r0_valid} !== {4'h3, 4'h3, 4'b0000}) begin
            errors++; $display("FAIL rd_lo_ram: got a=%h b=%h lohi=%0b%0b w_en=%0b rv=%0b exp 3 3 00 0 0", m0_addr_a, m0_addr_b, m0_lohi_a, m0_lohi_b, m0_w_en, r0_valid); end
        tick(); // RD_HI
        checks++; if ({m0_addr_a, m0_addr_b, m0_lohi_a, m0_lohi_b, r0_valid} !== {4'h3, 4'h3, 3'b110}) begin
            errors++; $display("FAIL rd_hi_ram: got a=%h b=%h lohi=%0b%0b rv=%0b exp 3 3 11 0", m0_addr_a, m0_addr_b, m0_lohi_a, m0_lohi_b, r0_valid); end
        tick(); // RSP, T+3
        checks++; if ({r0_valid, r0_da, r0_db} !== {1'b1, 8'hA5, 8'hA5}) begin
            errors++; $display("FAIL rd_rsp: got valid=%0b a=%h b=%h exp 1 a5 a5", r0_valid, r0_da, r0_db); end
        checks++; if ({c0_ready, m0_lohi_a, m0_addr_a, m0_w_en} !== 7'h0) begin
            errors++; $display("FAIL rd_rsp_ram_idle: got ready=%0b lohi=%0b addr=%h w_en=%0b exp 0", c0_ready, m0_lohi_a, m0_addr_a, m0_w_en); end
        r0_ready = 1;
        tick();
        r0_ready = 0;
        checks++; if ({r0_valid, c0_ready, r0_da, r0_db} !== {2'b01, 8'hA5, 8'hA5}) begin
            errors++; $display("FAIL rd_after_hs: got valid=%0b ready=%0b a=%h b=%h exp 0 1 a5 a5", r0_valid, c0_ready, r0_da, r0_db); end
    endtask

    task automatic test_rdlat1();
        c1_valid = 1; c1_write = 1; c1_addr_a = 0; c1_wdata = 8'h3C;
        tick();
        c1_valid = 0;
        tick(); tick();
        c1_valid = 1; c1_write = 1; c1_addr_a = 7; c1_wdata = 8'hF1;
        tick();
        c1_valid = 0;
        tick(); tick();
        checks++; if ({mem1[0], mem1[7]} !== 16'h3CF1) begin errors++; $display("FAIL lat1_mem: got %h %h exp 3c f1", mem1[0], mem1[7]); end
        c1_valid = 1; c1_write = 0; c1_addr_a = 0; c1_addr_b = 7;
        tick(); // RD_LO
        c1_valid = 0;
        checks++; if ({m1_lohi_a, m1_lohi_b, r1_valid} !== 3'b000) begin errors++; $display("FAIL lat1_rd_lo: got lohi=%0b%0b rv=%0b exp 00 0", m1_lohi_a, m1_lohi_b, r1_valid); end
        tick(); // RD_HI
        checks++; if ({m1_lohi_a, m1_lohi_b, r1_valid} !== 3'b110) begin errors++; $display("FAIL lat1_rd_hi: got lohi=%0b%0b rv=%0b exp 11 0", m1_lohi_a, m1_lohi_b, r1_valid); end
        tick(); // RD_DRAIN
        checks++; if ({m1_addr_a, m1_addr_b, m1_lohi_a, m1_lohi_b, r1_valid, busy1} !== {4'h0, 4'h7, 4'b1101}) begin
            errors++; $display("FAIL lat1_drain: got a=%h b=%h lohi=%0b%0b rv=%0b busy=%0b exp 0 7 11 0 1", m1_addr_a, m1_addr_b, m1_lohi_a, m1_lohi_b, r1_valid, busy1); end
        tick(); // RSP, T+4
        checks++; if ({r1_valid, r1_da, r1_db} !== {1'b1, 8'h3C, 8'hF1}) begin
            errors++; $display("FAIL lat1_rsp: got valid=%0b a=%h b=%h exp 1 3c f1", r1_valid, r1_da, r1_db); end
        r1_ready = 1;
        tick();
        r1_ready = 0;
        checks++; if ({r1_valid, c1_ready} !== 2'b01) begin errors++; $display("FAIL lat1_after_hs: got valid=%0b ready=%0b exp 0 1", r1_valid, c1_ready); end
    endtask

    task automatic test_back_to_back();
        int base;
        c0_valid = 1; c0_write = 1; c0_addr_a = 5; c0_wdata = 8'h12;
        tick(); // first write accepted
        c0_addr_a = 6; c0_wdata = 8'h34;
        checks++; if (c0_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_t1: got %0b exp 0", c0_ready); end
        tick();
        checks++; if ({c0_ready, m0_wdata, m0_addr_a} !== {1'b0, 4'h1, 4'h5}) begin
            errors++; $display("FAIL b2b_wr_hi: got ready=%0b wdata=%h addr=%h exp 0 1 5", c0_ready, m0_wdata, m0_addr_a); end
        tick();
        checks++; if (c0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_t3: got %0b exp 1", c0_ready); end
        tick(); // second write accepted three cycles after the first
        checks++; if ({m0_w_en, m0_addr_a, m0_wdata} !== {1'b1, 4'h6, 4'h4}) begin
            errors++; $display("FAIL b2b_second_wr: got w_en=%0b addr=%h wdata=%h exp 1 6 4", m0_w_en, m0_addr_a, m0_wdata); end
        c0_write = 0; c0_addr_a = 5; c0_addr_b = 6;
        tick(); tick();
        checks++; if (c0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_before_rd: got %0b exp 1", c0_ready); end
        tick(); // read accepted
        base = wen0_cnt;
        c0_write = 1; c0_addr_a = 5; c0_wdata = 8'hFF; // held but must be ignored
        tick(); tick(); // RSP
        checks++; if ({r0_valid, r0_da, r0_db} !== {1'b1, 8'h12, 8'h34}) begin
            errors++; $display("FAIL b2b_rsp: got valid=%0b a=%h b=%h exp 1 12 34", r0_valid, r0_da, r0_db); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({r0_valid, c0_ready, r0_da, r0_db} !== {2'b10, 8'h12, 8'h34}) begin
                errors++; $display("FAIL b2b_stall%0d: got valid=%0b ready=%0b a=%h b=%h exp 1 0 12 34", i, r0_valid, c0_ready, r0_da, r0_db); end
        end
        r0_ready = 1;
        tick();
        r0_ready = 0; c0_valid = 0;
        checks++; if ({r0_valid, c0_ready} !== 2'b01) begin errors++; $display("FAIL b2b_after_hs: got valid=%0b ready=%0b exp 0 1", r0_valid, c0_ready); end
        checks++; if (wen0_cnt - base !== 0) begin errors++; $display("FAIL b2b_no_wen_in_read: got %0d exp 0", wen0_cnt - base); end
        checks++; if ({mem0[5], mem0[6]} !== 16'h1234) begin errors++; $display("FAIL b2b_mem: got %h %h exp 12 34", mem0[5], mem0[6]); end
        tick();
    endtask

    task automatic test_reset_mid_write();
        c0_valid = 1; c0_write = 1; c0_addr_a = 2; c0_wdata = 8'h4B;
        tick();
        c0_valid = 0;
        tick(); tick();
        checks++; if (mem0[2] !== 8'h4B) begin errors++; $display("FAIL mid_rst_pre: got %h exp 4b", mem0[2]); end
        c0_valid = 1; c0_wdata = 8'h96;
        tick(); // WR_LO; reset sampled at the edge that would enter WR_HI
        c0_valid = 0; rst_n = 0;
        tick();
        checks++; if ({m0_w_en, busy0, c0_ready} !== 3'b000) begin
            errors++; $display("FAIL mid_rst_abort: got w_en=%0b busy=%0b ready=%0b exp 0 0 0", m0_w_en, busy0, c0_ready); end
        rst_n = 1;
        tick();
        checks++; if (mem0[2] !== 8'h46) begin errors++; $display("FAIL mid_rst_mem: got %h exp 46", mem0[2]); end
        c0_valid = 1; c0_write = 0; c0_addr_a = 2; c0_addr_b = 2;
        tick();
        c0_valid = 0;
        tick(); tick();
        checks++; if ({r0_valid, r0_da, r0_db} !== {1'b1, 8'h46, 8'h46}) begin
            errors++; $display("FAIL mid_rst_read: got valid=%0b a=%h b=%h exp 1 46 46", r0_valid, r0_da, r0_db); end
        r0_ready = 1;
        tick();
        r0_ready = 0;
    endtask

    task automatic test_random_hold();
        int base;
        c0_valid = 1; c0_write = 1; c0_addr_a = 9; c0_wdata = 8'h7E;
        tick(); // WR_LO
        for (int i = 0; i < 3; i++) begin
            c0_valid = 1'($urandom_range(0, 1)); c0_write = 1'($urandom_range(0, 1));
            c0_addr_a = 4'($urandom_range(0, 15)); c0_addr_b = 4'($urandom_range(0, 15));
            c0_wdata = 8'($urandom_range(0, 255)); r0_ready = 1'($urandom_range(0, 1));
            #1;
            checks++; if ({m0_w_en, m0_lohi_a, m0_wdata, m0_addr_a, busy0} !== {2'b11, 4'hE, 4'h9, 1'b1}) begin
                errors++; $display("FAIL rnd_wr_lo%0d: got w_en=%0b lohi=%0b wdata=%h addr=%h busy=%0b exp 1 1 e 9 1", i, m0_w_en, m0_lohi_a, m0_wdata, m0_addr_a, busy0); end
        end
        tick(); // WR_HI must use latched data
        c0_valid = 0; r0_ready = 0;
        checks++; if ({m0_w_en, m0_lohi_a, m0_wdata, m0_addr_a} !== {2'b10, 4'h7, 4'h9}) begin
            errors++; $display("FAIL rnd_wr_hi: got w_en=%0b lohi=%0b wdata=%h addr=%h exp 1 0 7 9", m0_w_en, m0_lohi_a, m0_wdata, m0_addr_a); end
        tick();
        checks++; if (mem0[9] !== 8'h7E) begin errors++; $display("FAIL rnd_mem: got %h exp 7e", mem0[9]); end
        base = wen0_cnt;
        c0_valid = 1; c0_write = 0; c0_addr_a = 9; c0_addr_b = 3;
        tick(); // RD_LO
        c0_valid = 0;
        tick(); // RD_HI
        for (int i = 0; i < 3; i++) begin
            c0_valid = 1'($urandom_range(0, 1)); c0_write = 1'($urandom_range(0, 1));
            c0_addr_a = 4'($urandom_range(0, 15)); c0_addr_b = 4'($urandom_range(0, 15));
            c0_wdata = 8'($urandom_range(0, 255)); r0_ready = 1'($urandom_range(0, 1));
            #1;
            checks++; if ({m0_addr_a, m0_addr_b, m0_lohi_a, m0_lohi_b, m0_w_en, busy0} !== {4'h9, 4'h3, 4'b1101}) begin
                errors++; $display("FAIL rnd_rd_hi%0d: got a=%h b=%h lohi=%0b%0b w_en=%0b busy=%0b exp 9 3 11 0 1", i, m0_addr_a, m0_addr_b, m0_lohi_a, m0_lohi_b, m0_w_en, busy0); end
        end
        tick(); // RSP regardless of rsp_ready seen in RD_HI
        for (int i = 0; i < 3; i++) begin
            c0_valid = 1'($urandom_range(0, 1)); c0_write = 1'($urandom_range(0, 1));
            c0_addr_a = 4'($urandom_range(0, 15)); c0_wdata = 8'($urandom_range(0, 255));
            r0_ready = 0;
            #1;
            checks++; if ({r0_valid, busy0, r0_da, r0_db, m0_w_en, m0_lohi_a, m0_addr_a} !== {2'b11, 8'h7E, 8'hA5, 6'h0}) begin
                errors++; $display("FAIL rnd_rsp%0d: got valid=%0b busy=%0b a=%h b=%h w_en=%0b lohi=%0b addr=%h exp 1 1 7e a5 0 0 0", i, r0_valid, busy0, r0_da, r0_db, m0_w_en, m0_lohi_a, m0_addr_a); end
            tick();
        end
        c0_valid = 0; r0_ready = 1;
        tick();
        r0_ready = 0;
        checks++; if ({r0_valid, busy0, c0_ready} !== 3'b001) begin
            errors++; $display("FAIL rnd_after_hs: got valid=%0b busy=%0b ready=%0b exp 0 0 1", r0_valid, busy0, c0_ready); end
        checks++; if (wen0_cnt - base !== 0) begin errors++; $display("FAIL rnd_no_wen: got %0d exp 0", wen0_cnt - base); end
        checks++; if (mem0[3] !== 8'hA5) begin errors++; $display("FAIL rnd_mem3: got %h exp a5", mem0[3]); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rdlat1();
        test_back_to_back();
        test_reset_mid_write();
        test_random_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
